// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: FSM states, default widths and the
// encoding of which redirect source wins when an instruction completes.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        RD_SEQ,
        RD_BRANCH,
        RD_JUMP,
        RD_CALL,
        RD_RET,
        RD_HALT
    } redirect_t;

    // Highest-priority redirect among the completion outputs of the stage
    function automatic redirect_t decodeRedirect(input logic halt,
                                                 input logic ret,
                                                 input logic call,
                                                 input logic jump,
                                                 input logic brTaken);
        if (halt)         return RD_HALT;
        else if (ret)     return RD_RET;
        else if (call)    return RD_CALL;
        else if (jump)    return RD_JUMP;
        else if (brTaken) return RD_BRANCH;
        else              return RD_SEQ;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the instruction-memory, decoder and redirect signals around the
// fetch sequencer; master is the sequencer side, slave its environment.
import fetch_pkg::*;

interface fetch_sequencer_if #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();

    logic               start;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               done;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_offset;
    logic               jump;
    logic [ADDR_W-1:0]  jump_target;
    logic               call;
    logic               ret;
    logic               halt;
    logic               halted;
    logic               stack_err;

    modport master (
        input  start, imem_ready, imem_rdata, done, br_taken, br_offset,
               jump, jump_target, call, ret, halt,
        output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
               stack_err
    );

    modport slave (
        output start, imem_ready, imem_rdata, done, br_taken, br_offset,
               jump, jump_target, call, ret, halt,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
               stack_err
    );

endinterface

// File: rtl/fetch_sequencer_return_stack.sv
// Small LIFO of return addresses. Only the occupancy counter is reset; entry
// contents are don't-care until pushed.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;
    logic [AW-1:0]    w_topIdx;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_topIdx = r_count[AW-1:0] - AW'(1);
    assign o_top    = r_mem[w_topIdx];

    // Pop wins if both are requested so the pointer moves by at most one
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && !i_pop && !o_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_doPush) begin
            r_count <= r_count + (AW+1)'(1);
        end else if (w_doPop) begin
            r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_count[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the program counter: fetches one instruction per memory handshake,
// holds it for the decoder and picks the next address when it completes.
import fetch_pkg::*;

module fetch_sequencer #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic            clk,
    input  logic            rst,
    fetch_sequencer_if.master bus
);

    state_t             r_state;
    state_t             w_nextState;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_nextPc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instrPc;
    logic               r_stackErr;
    logic               w_setErr;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_seqPc;
    logic [ADDR_W-1:0]  w_branchPc;
    logic [ADDR_W-1:0]  w_stackTop;
    logic               w_stackFull;
    logic               w_stackEmpty;

    assign w_seqPc    = r_instrPc + ADDR_W'(1);
    assign w_branchPc = r_instrPc + bus.br_offset;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_seqPc),
        .o_top   (w_stackTop),
        .o_full  (w_stackFull),
        .o_empty (w_stackEmpty)
    );

    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_setErr    = 1'b0;
        case (r_state)
            IDLE:  if (bus.start) w_nextState = FETCH;
            FETCH: if (bus.imem_ready) w_nextState = ISSUE;
            ISSUE: begin
                if (bus.done) begin
                    w_nextState = FETCH;
                    case (decodeRedirect(bus.halt, bus.ret, bus.call,
                                         bus.jump, bus.br_taken))
                        RD_HALT: w_nextState = HALT;
                        RD_RET: begin
                            if (w_stackEmpty) begin
                                w_setErr = 1'b1;
                                w_nextPc = w_seqPc;
                            end else begin
                                w_pop    = 1'b1;
                                w_nextPc = w_stackTop;
                            end
                        end
                        // Overflowing call still redirects; only the return address is lost
                        RD_CALL: begin
                            w_push   = !w_stackFull;
                            w_setErr = w_stackFull;
                            w_nextPc = bus.jump_target;
                        end
                        RD_JUMP:   w_nextPc = bus.jump_target;
                        RD_BRANCH: w_nextPc = w_branchPc;
                        default:   w_nextPc = w_seqPc;
                    endcase
                end
            end
            HALT:    w_nextState = HALT;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= ADDR_W'(RESET_ADDR);
            r_instr    <= '0;
            r_instrPc  <= '0;
            r_stackErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            if (r_state == FETCH && bus.imem_ready) begin
                r_instr   <= bus.imem_rdata;
                r_instrPc <= r_pc;
            end
            if (w_setErr) r_stackErr <= 1'b1;
        end
    end

    assign bus.imem_req    = (r_state == FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instrPc;
    assign bus.instr_valid = (r_state == ISSUE);
    assign bus.halted      = (r_state == HALT);
    assign bus.stack_err   = r_stackErr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a memory whose word is {A5, address}
// and hand-computed fetch address sequences for each redirect kind.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checksTotal  = 0;
    int   checksPassed = 0;

    fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    fetch_sequencer #(
        .ADDR_W      (8),
        .INSTR_W     (16),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = {8'hA5, bus.imem_addr};

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearRedirects();
        bus.done        = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_offset   = 8'h00;
        bus.jump        = 1'b0;
        bus.jump_target = 8'h00;
        bus.call        = 1'b0;
        bus.ret         = 1'b0;
        bus.halt        = 1'b0;
    endtask

    task automatic applyStimulus(input logic doReset);
        rst = doReset;
        step();
        rst = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"},    32'(bus.imem_req),    32'h0);
        checkOutput({tag, "_addr"},   32'(bus.imem_addr),   32'h0);
        checkOutput({tag, "_valid"},  32'(bus.instr_valid), 32'h0);
        checkOutput({tag, "_instr"},  32'(bus.instr),       32'h0);
        checkOutput({tag, "_ipc"},    32'(bus.instr_pc),    32'h0);
        checkOutput({tag, "_halted"}, 32'(bus.halted),      32'h0);
        checkOutput({tag, "_err"},    32'(bus.stack_err),   32'h0);
    endtask

    // Checks a fetch at expPc (ready already high), then the issued instruction
    task automatic fetchAndIssue(input string tag, input logic [7:0] expPc);
        checkOutput({tag, "_req"},  32'(bus.imem_req),  32'h1);
        checkOutput({tag, "_addr"}, 32'(bus.imem_addr), 32'(expPc));
        step();
        checkOutput({tag, "_valid"}, 32'(bus.instr_valid), 32'h1);
        checkOutput({tag, "_ipc"},   32'(bus.instr_pc),    32'(expPc));
        checkOutput({tag, "_instr"}, 32'(bus.instr),       32'({8'hA5, expPc}));
    endtask

    task automatic completeIssue();
        bus.done = 1'b1;
        step();
        clearRedirects();
    endtask

    task automatic jumpTo(input logic [7:0] target);
        bus.jump        = 1'b1;
        bus.jump_target = target;
        completeIssue();
    endtask

    task automatic callTo(input logic [7:0] target);
        bus.call        = 1'b1;
        bus.jump_target = target;
        completeIssue();
    endtask

    task automatic doRet();
        bus.ret = 1'b1;
        completeIssue();
    endtask

    initial begin
        clearRedirects();
        bus.start      = 1'b0;
        bus.imem_ready = 1'b1;
        rst            = 1'b1;
        step();
        applyStimulus(1'b1);
        checkResetState("reset");

        // Sequential fetch, then wrap from 0xFF to 0x00
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        fetchAndIssue("seq0", 8'h00);
        completeIssue();
        fetchAndIssue("seq1", 8'h01);
        completeIssue();
        fetchAndIssue("seq2", 8'h02);
        jumpTo(8'hFF);
        fetchAndIssue("pcFF", 8'hFF);
        completeIssue();
        fetchAndIssue("wrap", 8'h00);
        jumpTo(8'h05);

        // Backward branch and jump-over-branch priority
        fetchAndIssue("br05", 8'h05);
        bus.br_taken  = 1'b1;
        bus.br_offset = 8'hFC;
        completeIssue();
        fetchAndIssue("brTgt", 8'h01);
        jumpTo(8'h05);
        fetchAndIssue("jb05", 8'h05);
        bus.br_taken    = 1'b1;
        bus.br_offset   = 8'hFC;
        bus.jump        = 1'b1;
        bus.jump_target = 8'h40;
        completeIssue();
        fetchAndIssue("jmpWin", 8'h40);
        jumpTo(8'h10);

        // Memory stalls three cycles at 0x10
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stallReq%0d", i),   32'(bus.imem_req),    32'h1);
            checkOutput($sformatf("stallAddr%0d", i),  32'(bus.imem_addr),   32'h10);
            checkOutput($sformatf("stallValid%0d", i), 32'(bus.instr_valid), 32'h0);
            step();
        end
        bus.imem_ready = 1'b1;
        fetchAndIssue("stall10", 8'h10);
        jumpTo(8'h20);

        // Call / return pair
        fetchAndIssue("call20", 8'h20);
        callTo(8'h80);
        fetchAndIssue("callTgt", 8'h80);
        jumpTo(8'h85);
        fetchAndIssue("ret85", 8'h85);
        doRet();
        fetchAndIssue("retTgt", 8'h21);
        checkOutput("errClean", 32'(bus.stack_err), 32'h0);

        // Five nested calls into a four-deep stack
        callTo(8'h50);
        fetchAndIssue("n1", 8'h50);
        callTo(8'h60);
        fetchAndIssue("n2", 8'h60);
        callTo(8'h70);
        fetchAndIssue("n3", 8'h70);
        callTo(8'h78);
        fetchAndIssue("n4", 8'h78);
        checkOutput("errFull", 32'(bus.stack_err), 32'h0);
        callTo(8'h90);
        checkOutput("errOvf", 32'(bus.stack_err), 32'h1);
        fetchAndIssue("n5", 8'h90);
        doRet();
        fetchAndIssue("pop1", 8'h71);
        doRet();
        fetchAndIssue("pop2", 8'h61);
        doRet();
        fetchAndIssue("pop3", 8'h51);
        doRet();
        fetchAndIssue("pop4", 8'h22);
        checkOutput("errSticky", 32'(bus.stack_err), 32'h1);

        // Return on an empty stack after a fresh reset
        applyStimulus(1'b1);
        checkResetState("reset2");
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        fetchAndIssue("r2s0", 8'h00);
        jumpTo(8'h30);
        fetchAndIssue("ret30", 8'h30);
        doRet();
        checkOutput("errEmpty", 32'(bus.stack_err), 32'h1);
        fetchAndIssue("retEmpty", 8'h31);

        // Halt wins over jump and ignores start
        jumpTo(8'h07);
        fetchAndIssue("halt07", 8'h07);
        bus.halt        = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_target = 8'h99;
        completeIssue();
        checkOutput("halted", 32'(bus.halted),   32'h1);
        checkOutput("haltReq", 32'(bus.imem_req), 32'h0);
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        checkOutput("haltStay", 32'(bus.halted),   32'h1);
        checkOutput("haltReq2", 32'(bus.imem_req), 32'h0);
        applyStimulus(1'b1);
        checkResetState("reset3");

        // Reset during a FETCH wait drops the late ready
        bus.imem_ready = 1'b0;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checkOutput("midFetchReq", 32'(bus.imem_req), 32'h1);
        bus.imem_ready = 1'b1;
        applyStimulus(1'b1);
        checkResetState("rstFetch");
        step();
        checkOutput("rstFetchIdle", 32'(bus.imem_req), 32'h0);

        // Reset during ISSUE drops the pending done and jump
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        fetchAndIssue("ri0", 8'h00);
        jumpTo(8'h33);
        fetchAndIssue("ri33", 8'h33);
        bus.done        = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_target = 8'h44;
        applyStimulus(1'b1);
        clearRedirects();
        checkResetState("rstIssue");
        step();
        checkOutput("rstIssueIdle",  32'(bus.imem_req),  32'h0);
        checkOutput("rstIssueAddr",  32'(bus.imem_addr), 32'h0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
